// File: rtl/serial_frame_transmitter.sv
// Framed serial transmitter: start(1), data MSB-first, optional parity, stop(s)=1, idle low.
// Define SERIAL_TX_BUFFER_EN to add a one-entry holding buffer for gapless back-to-back frames.
module serial_frame_transmitter #(
  parameter int DATA_W       = 7,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              tx_done
);

  localparam int PAR_EN    = (PARITY != 0) ? 1 : 0;
  localparam int REST_LEN  = DATA_W + PAR_EN + STOP_BITS;
  localparam int FRAME_LEN = 1 + REST_LEN;
  localparam int CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_LEN - 1);

  generate
    if (DATA_W < 1) begin : g_bad_data_w
      $error("serial_frame_transmitter: DATA_W must be >= 1");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("serial_frame_transmitter: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("serial_frame_transmitter: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
      $error("serial_frame_transmitter: CLKS_PER_BIT must be >= 1");
    end
  endgenerate

  // Everything after the start bit, built once at handshake so parity uses the captured word.
  logic [REST_LEN-1:0] in_rest;
  generate
    if (PARITY == 0) begin : g_no_par
      assign in_rest = {in_data, {STOP_BITS{1'b1}}};
    end else begin : g_par
      logic par_bit;
      assign par_bit = (PARITY == 2) ? ~^in_data : ^in_data;
      assign in_rest = {in_data, par_bit, {STOP_BITS{1'b1}}};
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    baud_reg, baud_next;
  logic [BIT_W-1:0]    bit_reg, bit_next;
  logic [REST_LEN-1:0] shift_reg, shift_next;
  logic                serial_reg, serial_next;
  logic                accept;
`ifdef SERIAL_TX_BUFFER_EN
  logic [REST_LEN-1:0] buf_reg, buf_next;
  logic                buf_full_reg, buf_full_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      serial_reg   <= 1'b0;
`ifdef SERIAL_TX_BUFFER_EN
      buf_reg      <= '0;
      buf_full_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      baud_reg     <= baud_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      serial_reg   <= serial_next;
`ifdef SERIAL_TX_BUFFER_EN
      buf_reg      <= buf_next;
      buf_full_reg <= buf_full_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    serial_next = serial_reg;
    tx_done     = 1'b0;
    busy        = (state_reg == SHIFT);
`ifdef SERIAL_TX_BUFFER_EN
    buf_next      = buf_reg;
    buf_full_next = buf_full_reg;
    in_ready      = !buf_full_reg;
`else
    in_ready      = (state_reg == IDLE);
`endif
    accept = in_valid && in_ready;

    case (state_reg)
      IDLE: begin
        serial_next = 1'b0;
        if (accept) begin
          state_next  = SHIFT;
          shift_next  = in_rest;
          serial_next = 1'b1;
          baud_next   = '0;
          bit_next    = '0;
        end
      end
      SHIFT: begin
        if (baud_reg != BAUD_LAST) begin
          baud_next = baud_reg + 1'b1;
        end else begin
          baud_next = '0;
          if (bit_reg != BIT_LAST) begin
            serial_next = shift_reg[REST_LEN-1];
            shift_next  = shift_reg << 1;
            bit_next    = bit_reg + 1'b1;
          end else begin
            tx_done  = 1'b1;
            bit_next = '0;
`ifdef SERIAL_TX_BUFFER_EN
            // Pending word (buffered or offered right now) starts with no idle gap.
            if (buf_full_reg) begin
              shift_next    = buf_reg;
              buf_full_next = 1'b0;
              serial_next   = 1'b1;
            end else if (accept) begin
              shift_next  = in_rest;
              serial_next = 1'b1;
            end else begin
              state_next  = IDLE;
              serial_next = 1'b0;
            end
`else
            state_next  = IDLE;
            serial_next = 1'b0;
`endif
          end
        end
`ifdef SERIAL_TX_BUFFER_EN
        if (accept && !tx_done) begin
          buf_next      = in_rest;
          buf_full_next = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  assign serial_out = serial_reg;

endmodule

// File: doc/serial_frame_transmitter.md
# serial_frame_transmitter

Parametrised successor to the team's fixed 7-bit serial data transmitter. Accepts parallel words over a valid/ready handshake and shifts them out MSB-first as framed serial data (start bit, data, optional parity, one or two stop bits) at a programmable clocks-per-bit rate. It sits between a word-producing block and the serial line and keeps the existing line convention: idle low, start bit high, stop bit(s) high.

## Interface
- DATA_W, 7, data bits per frame (≥1)
- PARITY, 1, 0 = none, 1 = even (parity bit = ^data), 2 = odd (parity bit = ~^data)
- STOP_BITS, 1, stop bits per frame (1 or 2)
- CLKS_PER_BIT, 1, clock cycles each bit is held on serial_out (≥1)
- clk  input  1  clock, all state on posedge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  DATA_W  word to transmit, sampled only on handshake
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word this cycle
- serial_out  output  1  serial line (registered)
- busy  output  1  frame in progress
- tx_done  output  1  one-cycle pulse on final cycle of last stop bit

## Operation
- Frame, in transmit order: start(1), in_data[DATA_W-1] … in_data[0], parity (if PARITY≠0), STOP_BITS × 1.
- FRAME_LEN = 1 + DATA_W + (PARITY≠0) + STOP_BITS bits; frame lasts FRAME_LEN × CLKS_PER_BIT cycles.
- FSM states: IDLE, SHIFT.
  - IDLE: serial_out = 0, busy = 0, in_ready = 1. On in_valid & in_ready: load frame shift register, clear bit and baud counters, go to SHIFT.
  - SHIFT: baud counter counts 0 … CLKS_PER_BIT-1; at terminal count, shift next bit out and increment bit counter. After last bit's terminal count: pulse tx_done, then start next frame if a word is pending, otherwise return to IDLE.
- Parity computed from the captured word at handshake; later changes on in_data have no effect.
- in_valid while in_ready = 0 is ignored; no word is lost because the producer must hold in_valid until it sees in_ready.
- Illegal parameter values (PARITY > 2, STOP_BITS not in {1,2}, CLKS_PER_BIT = 0) must stop elaboration with an error.

## Timing
- Reset values: serial_out 0, in_ready 1, busy 0, tx_done 0; FSM IDLE, counters and holding buffer cleared.
- Reset asserted mid-frame: serial_out drops to 0 immediately (asynchronous); the frame is abandoned and not resumed.
- Latency: handshake at edge N → start bit on serial_out from edge N through N+CLKS_PER_BIT; busy high from edge N.
- tx_done is high during the last clk cycle of the final stop bit. busy falls at the following edge unless a next frame starts.
- Without buffer: in_ready is low throughout SHIFT, and at least one idle-low cycle occurs between frames.
- A word presented in the same cycle that tx_done is high is not accepted, because in_ready = 0.

## Configuration
- SERIAL_TX_BUFFER_EN defined: adds a one-entry holding buffer.
  - in_ready = buffer empty, in every state.
  - A handshake during SHIFT stores the word.
  - At frame end with the buffer full, the next start bit follows the last stop bit directly, with no idle cycle, and the buffer empties.
  - A handshake in IDLE bypasses the buffer.
  - A handshake in the same cycle as tx_done with the buffer empty loads the word straight into the shifter for back-to-back transmission.
- SERIAL_TX_BUFFER_EN undefined: no buffer; in_ready is asserted in IDLE only.

## Test plan
- Defaults (7 bits, even parity, 1 stop, CLKS_PER_BIT=1), send 7'h55 → serial_out 1,1,0,1,0,1,0,1,0,1 on 10 consecutive cycles, then 0; tx_done on the 10th cycle.
- PARITY=2, STOP_BITS=2, send 7'h55 → 1,1,0,1,0,1,0,1,1,1,1 (11 bits).
- CLKS_PER_BIT=4, send 7'h7F → each bit held exactly 4 cycles: 40-cycle frame, parity 1.
- Unbuffered, in_valid held high with 7'h01 then 7'h02 → two frames separated by ≥1 cycle of serial_out = 0; in_ready low during each frame.
- SERIAL_TX_BUFFER_EN, second word offered mid-frame → accepted immediately; its start bit follows the first frame's stop bit with no gap; busy stays high across both frames.
- rst pulsed at bit 4 of a frame → serial_out = 0, busy = 0, in_ready = 1 within the reset cycle; the next handshake produces a clean full frame.
